instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumes the fetch PC from program_counter, issues word fetches to instruction memory over a valid/ready request channel, and collects in-order responses.
- Delivers {pc, instr} pairs to decode over a valid/ready channel.
- Drives the PC advance enable and discards in-flight and buffered fetches on a pipeline redirect (flush).
- Sits between program_counter and the decode stage.

Parameters:
- DEPTH, 4, total fetch slots (in-flight plus buffered); power of two, ≥2
- PTR_W, $clog2(DEPTH), slot pointer width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pc_i  input  32  current fetch PC from program_counter
- pc_en_o  output  1  advance PC; high exactly on a request handshake
- flush_i  input  1  redirect; discard all fetches this cycle
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts request
- imem_req_addr_o  output  32  {pc_i[31:2], 2'b00}
- imem_rsp_valid_i  input  1  response valid; in order, always accepted
- imem_rsp_data_i  input  32  instruction word
- if_valid_o  output  1  fetched instruction available
- if_ready_i  input  1  decode accepts
- if_instr_o  output  32  instruction at read slot
- if_pc_o  output  32  PC of that instruction

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc, instr, filled}.
- Three pointers, each PTR_W+1 bits with a wrap bit:
  - alloc_ptr: advances on request handshake; writes pc into the slot and clears filled.
  - fill_ptr: advances on an accepted, non-discarded response; writes instr and sets filled.
  - rd_ptr: advances on if_valid_o && if_ready_i.
- Counts:
  - used = alloc_ptr - rd_ptr, range 0..DEPTH
  - outstanding = alloc_ptr - fill_ptr
- imem_req_valid_o = rst_n && !flush_i && (used < DEPTH). It is combinational and must not depend on imem_req_ready_i.
- pc_en_o = imem_req_valid_o && imem_req_ready_i. Top level ORs the flush redirect into the PC enable separately.
- if_valid_o = (rd_ptr != fill_ptr) && !flush_i. if_instr_o and if_pc_o come from the rd_ptr slot and are don't-care when if_valid_o is low.
- Zero-latency bypass is not required. A response is visible on if_valid_o the cycle after it arrives.
- Simultaneous events in one cycle:
  - Request, response and decode pop may all occur; each pointer updates independently.
  - A full buffer with a pop in the same cycle still blocks a request that cycle, because used is evaluated pre-update.
- Flush:
  - All three pointers reset to 0.
  - discard_cnt <= outstanding - (imem_rsp_valid_i ? 1 : 0), counting only non-discarded responses.
  - No request and no pop occur in the flush cycle.
- Discard counter:
  - While discard_cnt > 0, each imem_rsp_valid_i decrements discard_cnt and the data is dropped.
  - discard_cnt is PTR_W+1 bits and never underflows.
  - A flush while discard_cnt > 0 adds the new outstanding to the remaining discard_cnt.
- Requests resume the cycle after flush, with buffer space available.
- Response with outstanding == 0 and discard_cnt == 0: protocol violation, ignored, with a simulation-only assertion.
- Reset (async assert, sync deassert expected externally):
  - All pointers and discard_cnt are 0.
  - imem_req_valid_o = 0, pc_en_o = 0, if_valid_o = 0.
  - Buffer contents are not reset.
- Reset asserted mid-operation drops everything immediately. Memory responses still pending are the system's responsibility; memory is reset together with this block.

Test Plan:
- Reset then streaming:
  - Stimulus: pc_i steps 0x80000000, +4, …; memory always ready; 1-cycle response latency; decode always ready.
  - Response: pc_en_o high every cycle; if_pc_o/if_instr_o pairs match in order with no gaps after a 2-cycle fill.
- Backpressure:
  - Stimulus: if_ready_i = 0.
  - Response: exactly DEPTH=4 handshakes, then imem_req_valid_o = 0 and pc_en_o = 0. Raising if_ready_i for one cycle pops 0x80000000 and allows exactly one new request, which starts the cycle after the pop.
- Memory stall:
  - Stimulus: imem_req_ready_i = 0 for 5 cycles.
  - Response: imem_req_valid_o held high, addr stable at pc_i, pc_en_o = 0 throughout.
- Flush with 3 outstanding, including a response arriving in the flush cycle:
  - Response: discard_cnt = 2; the next 2 responses are dropped.
  - The first if_valid_o after flush carries the redirect PC (e.g. 0x80000100) with its instruction.
- Back-to-back flushes:
  - Stimulus: 2 outstanding, flush, one new request issued, flush again.
  - Response: discard_cnt reaches 3; exactly 3 responses are dropped.
- Reset mid-stream:
  - Stimulus: rst_n low for 1 cycle with buffered entries.
  - Response: all outputs are 0 asynchronously, and no stale instruction appears after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches for the current PC, buffers the
// in-order memory responses and hands {pc, instr} pairs to decode.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
);

  localparam logic [PTR_W:0]   DEPTH_CNT   = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   PTR_ONE     = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W+1:0] WIDE_ONE    = {{(PTR_W+1){1'b0}}, 1'b1};
  localparam logic [PTR_W+1:0] DISCARD_MAX = {1'b0, {(PTR_W+1){1'b1}}};

  logic [31:0]      slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [PTR_W:0]   alloc_ptr;
  logic [PTR_W:0]   fill_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   discard_cnt;
  logic [PTR_W:0]   used;
  logic [PTR_W:0]   outstanding;
  logic [PTR_W-1:0] alloc_idx;
  logic [PTR_W-1:0] fill_idx;
  logic [PTR_W-1:0] rd_idx;

  logic             req_fire;
  logic             rsp_fill;
  logic             rsp_drop;
  logic             pop;
  logic [PTR_W+1:0] discard_sum;
  logic [PTR_W+1:0] discard_sum_adj;
  logic [PTR_W:0]   discard_next;
  logic             unused_pc_lsb;

  assign used        = alloc_ptr - rd_ptr;
  assign outstanding = alloc_ptr - fill_ptr;
  assign alloc_idx   = alloc_ptr[PTR_W-1:0];
  assign fill_idx    = fill_ptr[PTR_W-1:0];
  assign rd_idx      = rd_ptr[PTR_W-1:0];

  // Request side is purely a function of occupancy, never of imem_req_ready_i.
  assign imem_req_valid_o = rst_n && !flush_i && (used < DEPTH_CNT);
  assign imem_req_addr_o  = {pc_i[31:2], 2'b00};
  assign pc_en_o          = imem_req_valid_o && imem_req_ready_i;
  assign req_fire         = pc_en_o;
  assign unused_pc_lsb    = ^pc_i[1:0];

  assign if_valid_o = (rd_ptr != fill_ptr) && slot_filled[rd_idx] && !flush_i;
  assign if_instr_o = slot_instr[rd_idx];
  assign if_pc_o    = slot_pc[rd_idx];
  assign pop        = if_valid_o && if_ready_i;

  // Responses owed to fetches killed by an earlier flush are dropped first.
  assign rsp_drop = imem_rsp_valid_i && !flush_i && (discard_cnt != '0);
  assign rsp_fill = imem_rsp_valid_i && !flush_i && (discard_cnt == '0) &&
                    (outstanding != '0);

  // On flush every response still owed becomes a discard, minus the one
  // landing this very cycle; clamp at zero and at the counter's range.
  assign discard_sum     = {1'b0, discard_cnt} + {1'b0, outstanding};
  assign discard_sum_adj = (imem_rsp_valid_i && (discard_sum != '0)) ?
                           (discard_sum - WIDE_ONE) : discard_sum;
  assign discard_next    = (discard_sum_adj > DISCARD_MAX) ?
                           DISCARD_MAX[PTR_W:0] : discard_sum_adj[PTR_W:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      discard_cnt <= '0;
    end else if (flush_i) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      discard_cnt <= discard_next;
    end else begin
      if (req_fire) alloc_ptr   <= alloc_ptr + PTR_ONE;
      if (rsp_fill) fill_ptr    <= fill_ptr + PTR_ONE;
      if (pop)      rd_ptr      <= rd_ptr + PTR_ONE;
      if (rsp_drop) discard_cnt <= discard_cnt - PTR_ONE;
    end
  end

  // Slot storage is not reset; pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_pc[alloc_idx]     <= pc_i;
      slot_filled[alloc_idx] <= 1'b0;
    end
    if (rsp_fill) begin
      slot_instr[fill_idx]  <= imem_rsp_data_i;
      slot_filled[fill_idx] <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid_i && (outstanding == '0) && (discard_cnt == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios and a randomized run, checked
// against a queue-level model of the fetch buffer plus an in-order memory.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc_i),
    .pc_en_o          (pc_en_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .if_valid_o       (if_valid_o),
    .if_ready_i       (if_ready_i),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } slot_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  slot_t       mq[$];     // fetches since the last flush, oldest first
  mem_t        mem_q[$];  // requests the memory still owes a response for
  int          m_discard;
  int          cyc = 0;
  int          last_due = 0;
  int          mem_lat = 1;
  bit          mem_hold = 0;
  logic [31:0] redirect_pc = 32'h0;

  bit          exp_req_valid, exp_pc_en, exp_if_valid;
  logic [31:0] exp_addr, exp_if_pc, exp_if_instr;

  // Drive memory response for this cycle and derive expected outputs.
  task automatic settle();
    @(negedge clk);
    if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_q[0].data;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = $urandom;
    end
    #1;
    exp_req_valid = rst_n && !flush_i && (mq.size() < DEPTH);
    exp_pc_en     = exp_req_valid && imem_req_ready_i;
    exp_addr      = {pc_i[31:2], 2'b00};
    exp_if_valid  = rst_n && !flush_i && (mq.size() > 0) && mq[0].filled;
    exp_if_pc     = (mq.size() > 0) ? mq[0].pc : 32'h0;
    exp_if_instr  = (mq.size() > 0) ? mq[0].instr : 32'h0;
  endtask

  // Advance memory, model and program counter across one clock edge.
  task automatic commit();
    bit          rsp;
    int          out_cnt;
    mem_t        m;
    slot_t       s;
    logic [31:0] pc_next;
    rsp = imem_rsp_valid_i;
    if (rsp) void'(mem_q.pop_front());
    if (imem_req_valid_o && imem_req_ready_i) begin
      m.data = $urandom;
      m.due  = cyc + mem_lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
    end
    if (flush_i) begin
      out_cnt = 0;
      foreach (mq[i]) if (!mq[i].filled) out_cnt++;
      m_discard = m_discard + out_cnt - (rsp ? 1 : 0);
      if (m_discard < 0) m_discard = 0;
      mq.delete();
    end else begin
      if (exp_if_valid && if_ready_i) void'(mq.pop_front());
      if (rsp) begin
        if (m_discard > 0) m_discard--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              s = mq[i]; s.instr = imem_rsp_data_i; s.filled = 1'b1; mq[i] = s;
              break;
            end
          end
        end
      end
      if (exp_pc_en) begin
        s.pc = pc_i; s.instr = 32'h0; s.filled = 1'b0;
        mq.push_back(s);
      end
    end
    pc_next = flush_i ? redirect_pc : (exp_pc_en ? pc_i + 32'd4 : pc_i);
    cyc++;
    @(posedge clk);
    #1;
    pc_i = pc_next;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush_i = 1'b0; imem_req_ready_i = 1'b0; if_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    mq.delete(); mem_q.delete(); m_discard = 0; mem_hold = 0; mem_lat = 1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; imem_req_ready_i = 1'b1; if_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0; pc_i = 32'h8000_0000;
    mq.delete(); mem_q.delete(); m_discard = 0;
    #1;
    total++;
    if (imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid_o); end
    total++;
    if (pc_en_o !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%b want=0", pc_en_o); end
    total++;
    if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b want=0", if_valid_o); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    settle();
    total++;
    if (pc_en_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000)
      begin bad++; $display("FAIL rst_first_req pc_en=%b addr=%h want 1/80000000", pc_en_o, imem_req_addr_o); end
    commit();
  endtask

  task automatic test_streaming();
    do_reset();
    pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; if_ready_i = 1'b1;
    for (int n = 0; n < 16; n++) begin
      settle();
      total++;
      if (pc_en_o !== 1'b1) begin bad++; $display("FAIL stream_pc_en n=%0d got=%b want=1", n, pc_en_o); end
      total++;
      if (n < 2) begin
        if (if_valid_o !== 1'b0) begin bad++; $display("FAIL stream_fill n=%0d if_valid=%b want=0", n, if_valid_o); end
      end else if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0000 + 32'(4 * (n - 2)) ||
                   if_instr_o !== exp_if_instr) begin
        bad++;
        $display("FAIL stream_out n=%0d valid=%b pc=%h instr=%h want 1/%h/%h", n, if_valid_o, if_pc_o,
                 if_instr_o, 32'h8000_0000 + 32'(4 * (n - 2)), exp_if_instr);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    do_reset();
    pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; if_ready_i = 1'b0;
    for (int n = 0; n < 8; n++) begin
      settle();
      if (pc_en_o === 1'b1) hs++;
      total++;
      if (pc_en_o !== exp_pc_en) begin bad++; $display("FAIL bp_pc_en n=%0d got=%b want=%b", n, pc_en_o, exp_pc_en); end
      commit();
    end
    total++;
    if (hs != DEPTH) begin bad++; $display("FAIL bp_handshakes got=%0d want=%0d", hs, DEPTH); end
    settle();
    total++;
    if (imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL bp_full_valid got=%b want=0", imem_req_valid_o); end
    commit();
    if_ready_i = 1'b1;
    settle();
    total++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0000 || if_instr_o !== exp_if_instr)
      begin bad++; $display("FAIL bp_pop valid=%b pc=%h instr=%h want 1/80000000/%h", if_valid_o, if_pc_o, if_instr_o, exp_if_instr); end
    total++;
    if (pc_en_o !== 1'b0) begin bad++; $display("FAIL bp_pop_blocks_req got=%b want=0", pc_en_o); end
    commit();
    if_ready_i = 1'b0;
    settle();
    total++;
    if (pc_en_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0010)
      begin bad++; $display("FAIL bp_refill pc_en=%b addr=%h want 1/80000010", pc_en_o, imem_req_addr_o); end
    commit();
    settle();
    total++;
    if (pc_en_o !== 1'b0) begin bad++; $display("FAIL bp_refull got=%b want=0", pc_en_o); end
    commit();
  endtask

  task automatic test_mem_stall();
    do_reset();
    pc_i = 32'h8000_0006; imem_req_ready_i = 1'b0; if_ready_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      settle();
      total++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0004 || pc_en_o !== 1'b0)
        begin bad++; $display("FAIL stall n=%0d valid=%b addr=%h pc_en=%b want 1/80000004/0", n, imem_req_valid_o, imem_req_addr_o, pc_en_o); end
      commit();
    end
    imem_req_ready_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      settle();
      total++;
      if (pc_en_o !== 1'b1 || imem_req_addr_o !== exp_addr)
        begin bad++; $display("FAIL stall_release n=%0d pc_en=%b addr=%h want 1/%h", n, pc_en_o, imem_req_addr_o, exp_addr); end
      total++;
      if (if_valid_o !== exp_if_valid || (exp_if_valid && (if_pc_o !== exp_if_pc || if_instr_o !== exp_if_instr)))
        begin bad++; $display("FAIL stall_out n=%0d valid=%b pc=%h want %b/%h", n, if_valid_o, if_pc_o, exp_if_valid, exp_if_pc); end
      commit();
    end
  endtask

  task automatic test_flush();
    bit first = 1'b1;
    do_reset();
    pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; if_ready_i = 1'b1; mem_hold = 1'b1;
    for (int n = 0; n < 3; n++) begin settle(); commit(); end
    mem_hold = 1'b0; flush_i = 1'b1; redirect_pc = 32'h8000_0100;
    settle();
    total++;
    if (imem_req_valid_o !== 1'b0 || pc_en_o !== 1'b0 || if_valid_o !== 1'b0)
      begin bad++; $display("FAIL flush_cycle req=%b pc_en=%b if_valid=%b want 0/0/0", imem_req_valid_o, pc_en_o, if_valid_o); end
    commit();
    flush_i = 1'b0;
    total++;
    if (dut.discard_cnt !== 3'd2) begin bad++; $display("FAIL flush_discard_cnt got=%0d want=2", dut.discard_cnt); end
    for (int n = 0; n < 12; n++) begin
      settle();
      total++;
      if (if_valid_o !== exp_if_valid || (exp_if_valid && (if_pc_o !== exp_if_pc || if_instr_o !== exp_if_instr)))
        begin bad++; $display("FAIL flush_out n=%0d valid=%b pc=%h instr=%h want %b/%h/%h", n, if_valid_o, if_pc_o, if_instr_o, exp_if_valid, exp_if_pc, exp_if_instr); end
      if (if_valid_o === 1'b1 && first) begin
        first = 1'b0;
        total++;
        if (if_pc_o !== 32'h8000_0100) begin bad++; $display("FAIL flush_first_pc got=%h want=80000100", if_pc_o); end
      end
      commit();
    end
    total++;
    if (first) begin bad++; $display("FAIL flush_no_output got=none want=80000100"); end
  endtask

  task automatic test_back_to_back();
    bit first = 1'b1;
    do_reset();
    pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; if_ready_i = 1'b1; mem_hold = 1'b1;
    for (int n = 0; n < 2; n++) begin settle(); commit(); end
    flush_i = 1'b1; redirect_pc = 32'h8000_0200;
    settle(); commit();
    flush_i = 1'b0;
    total++;
    if (dut.discard_cnt !== 3'd2) begin bad++; $display("FAIL b2b_discard1 got=%0d want=2", dut.discard_cnt); end
    settle();
    total++;
    if (pc_en_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0200)
      begin bad++; $display("FAIL b2b_resume pc_en=%b addr=%h want 1/80000200", pc_en_o, imem_req_addr_o); end
    commit();
    flush_i = 1'b1; redirect_pc = 32'h8000_0300;
    settle(); commit();
    flush_i = 1'b0;
    total++;
    if (dut.discard_cnt !== 3'd3) begin bad++; $display("FAIL b2b_discard2 got=%0d want=3", dut.discard_cnt); end
    mem_hold = 1'b0;
    for (int n = 0; n < 12; n++) begin
      settle();
      total++;
      if (dut.discard_cnt !== 3'(m_discard)) begin bad++; $display("FAIL b2b_discard_track n=%0d got=%0d want=%0d", n, dut.discard_cnt, m_discard); end
      total++;
      if (if_valid_o !== exp_if_valid || (exp_if_valid && (if_pc_o !== exp_if_pc || if_instr_o !== exp_if_instr)))
        begin bad++; $display("FAIL b2b_out n=%0d valid=%b pc=%h instr=%h want %b/%h/%h", n, if_valid_o, if_pc_o, if_instr_o, exp_if_valid, exp_if_pc, exp_if_instr); end
      if (if_valid_o === 1'b1 && first) begin
        first = 1'b0;
        total++;
        if (if_pc_o !== 32'h8000_0300) begin bad++; $display("FAIL b2b_first_pc got=%h want=80000300", if_pc_o); end
      end
      commit();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; if_ready_i = 1'b0;
    for (int n = 0; n < 6; n++) begin settle(); commit(); end
    total++;
    if (if_valid_o !== 1'b1) begin bad++; $display("FAIL midrst_prefill got=%b want=1", if_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req_valid_o !== 1'b0 || pc_en_o !== 1'b0 || if_valid_o !== 1'b0)
      begin bad++; $display("FAIL midrst_async req=%b pc_en=%b if_valid=%b want 0/0/0", imem_req_valid_o, pc_en_o, if_valid_o); end
    mq.delete(); mem_q.delete(); m_discard = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1; last_due = cyc;
    pc_i = 32'h8000_0400; if_ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      settle();
      total++;
      if (if_valid_o !== exp_if_valid || (exp_if_valid && (if_pc_o !== exp_if_pc || if_instr_o !== exp_if_instr)))
        begin bad++; $display("FAIL midrst_out n=%0d valid=%b pc=%h instr=%h want %b/%h/%h", n, if_valid_o, if_pc_o, if_instr_o, exp_if_valid, exp_if_pc, exp_if_instr); end
      commit();
    end
  endtask

  task automatic test_random();
    do_reset();
    pc_i = 32'h8000_1000;
    for (int n = 0; n < 400; n++) begin
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      if_ready_i       = ($urandom_range(0, 3) != 0);
      flush_i          = ($urandom_range(0, 19) == 0);
      mem_lat          = $urandom_range(1, 3);
      if (flush_i) redirect_pc = $urandom & 32'hFFFF_FFFC;
      settle();
      total++;
      if (imem_req_valid_o !== exp_req_valid || pc_en_o !== exp_pc_en || imem_req_addr_o !== exp_addr)
        begin bad++; $display("FAIL rnd_req n=%0d valid=%b pc_en=%b addr=%h want %b/%b/%h", n, imem_req_valid_o, pc_en_o, imem_req_addr_o, exp_req_valid, exp_pc_en, exp_addr); end
      total++;
      if (if_valid_o !== exp_if_valid || (exp_if_valid && (if_pc_o !== exp_if_pc || if_instr_o !== exp_if_instr)))
        begin bad++; $display("FAIL rnd_out n=%0d valid=%b pc=%h instr=%h want %b/%h/%h", n, if_valid_o, if_pc_o, if_instr_o, exp_if_valid, exp_if_pc, exp_if_instr); end
      total++;
      if (dut.discard_cnt !== 3'(m_discard)) begin bad++; $display("FAIL rnd_discard n=%0d got=%0d want=%0d", n, dut.discard_cnt, m_discard); end
      commit();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mem_stall();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
